hazard_ctrl_mc: RTL and testbench
=================================

// Module: hazard_ctrl_mc
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage RV32I core (F/D/E/M/W).
//  Generates per-stage stall/flush and E-stage operand forwarding. Handles load-use
//  with configurable load latency, multi-cycle execute ops (mul/div), data-memory wait
//  states with a watchdog, and branch/jump redirects. Sits beside the datapath;
//  drives the enables/clears of every pipeline register.
// PARAMETERS
//  REG_AW       5    register address width
//  LOAD_LAT     1    cycles (>=1) a load-dependent instr in D must wait
//  MEM_TIMEOUT  255  max consecutive MEM_WAIT cycles before MemTimeout sets (>=1)
//  CNT_W        8    width of load and timeout counters; must hold LOAD_LAT, MEM_TIMEOUT
// PORTS
//  clk          in   1       core clock, rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  Rs1D,Rs2D    in   REG_AW  source regs of instr in D
//  Rs1E,Rs2E    in   REG_AW  source regs of instr in E
//  RdE,RdM,RdW  in   REG_AW  dest regs in E/M/W
//  RegWriteM/W  in   1       M/W instr writes the register file
//  ResultSrcE   in   2       2'b01 = load in E
//  PCSrcE       in   1       taken branch/jump resolved in E
//  McBusyE      in   1       multi-cycle op in E not yet complete
//  MemReqM      in   1       M instr accesses data memory
//  MemReadyM    in   1       data memory completes access this cycle
//  StallF,StallD,StallE,StallM out 1  hold the stage's pipeline register
//  FlushD,FlushE,FlushM,FlushW out 1  insert a bubble into the stage's register
//  ForwardAE,ForwardBE out 2  00 regfile, 10 from M, 01 from W
//  MemTimeout   out  1       sticky error: MEM_WAIT exceeded MEM_TIMEOUT
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, counters=0, MemTimeout=0. While reset is
//   asserted all stall/flush/forward outputs are 0.
//  States: IDLE, LU_STALL, MC_EXEC, MEM_WAIT. Outputs are combinational from state+inputs.
//  Priority (highest first): mem wait > multi-cycle > redirect > load-use.
//  mem wait: MemReqM & !MemReadyM -> StallF/D/E/M=1, FlushW=1, everything else 0;
//   next state MEM_WAIT. MemReadyM=1 ends the wait in the same cycle (no stall); the
//   FSM returns to IDLE. The timeout counter increments each MEM_WAIT cycle and clears
//   on exit; when it reaches MEM_TIMEOUT, MemTimeout sets and holds until reset.
//  multi-cycle: McBusyE (no mem wait) -> StallF/D/E=1, FlushM=1; state MC_EXEC.
//   Exits when McBusyE drops.
//  redirect: PCSrcE is honoured only when E is not stalled -> FlushD=1, FlushE=1.
//   A redirect during LU_STALL aborts it (counter cleared, state to IDLE).
//  load-use: lu = (ResultSrcE==2'b01) & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
//   From IDLE, lu -> StallF=1, StallD=1, FlushE=1. If LOAD_LAT>1, the counter loads
//   LOAD_LAT-1 and the state goes to LU_STALL. LU_STALL holds StallF/D and FlushE and
//   decrements the counter. It returns to IDLE in the cycle the counter reaches 0.
//   Total stall is exactly LOAD_LAT cycles. A mem wait or multi-cycle op arriving
//   during LU_STALL freezes the counter and takes priority.
//   LU_STALL is resumed afterwards (it is saved in a return flag).
//  x0: a source or dest of 0 never matches, for both stall and forwarding.
//  Forwarding: ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW &
//   RdW!=0 & RdW==Rs1E; else 00. M wins over W. Same for ForwardBE with Rs2E.
//   Forwarding is active in every state.
// STRUCTURE
//  hazard_pkg: state enum, FWD_REG/FWD_M/FWD_W constants, RESULT_LOAD=2'b01.
//  Sub-module hazard_forward (pure combinational, one rs -> 2-bit select), instanced x2.
//  FSM and counters stay in hazard_ctrl_mc.
// TESTING
//  LOAD_LAT=1: load x5 in E, Rs1D=5 -> 1 cycle StallF/D+FlushE, then IDLE.
//   Same with RdE=0 -> no stall.
//  LOAD_LAT=3: load x7, Rs2D=7 -> StallF/D+FlushE for exactly 3 cycles.
//   PCSrcE in cycle 2 -> FlushD/E, abort, IDLE next cycle.
//  MemReqM=1, MemReadyM=0 for 4 cycles -> StallF..M+FlushW for 4 cycles.
//   Ready on cycle 5 -> all 0; MemTimeout stays 0.
//  MEM_TIMEOUT=3, ready held low 5 cycles -> MemTimeout=1 from cycle 3.
//   It stays 1 after ready; reset_n low clears it asynchronously.
//  McBusyE high 6 cycles while PCSrcE=1 -> no FlushD during busy.
//   FlushD/E in the first cycle after busy drops.
//  RdM=RdW=9, both write, Rs1E=9 -> ForwardAE=10. RegWriteM=0 -> 01. Rs1E=0 -> 00.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by the hazard controller and its forwarding selectors.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LU_STALL,
        ST_MC_EXEC,
        ST_MEM_WAIT
    } hz_state_t;

    localparam logic [1:0] FWD_REG     = 2'b00;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_forward.sv
// E-stage operand forwarding select for one source register.
// M result beats W result; x0 never forwards.
module hazard_forward
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_rd_m,
    input  logic [REG_AW-1:0] i_rd_w,
    input  logic              i_reg_write_m,
    input  logic              i_reg_write_w,
    output logic [1:0]        o_fwd
);

    logic w_hit_m;
    logic w_hit_w;

    assign w_hit_m = i_reg_write_m & (i_rd_m != '0)
                   & (i_rd_m == i_rs);
    assign w_hit_w = i_reg_write_w & (i_rd_w != '0)
                   & (i_rd_w == i_rs) & ~w_hit_m;

    // pick the youngest producer of the operand
    always_comb begin
        o_fwd = FWD_REG;
        unique case (1'b1)
            w_hit_m: o_fwd = FWD_M;
            w_hit_w: o_fwd = FWD_W;
            default: o_fwd = FWD_REG;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage core: stall/flush per stage,
// load-use interlock, multi-cycle execute, memory wait, forwarding.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    input  logic              McBusyE,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              FlushW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MemTimeout
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(MEM_TIMEOUT - 1);

    hz_state_t        r_state;
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_to_cnt;
    logic             r_lu_ret;
    logic             r_timeout;

    logic       w_mem_wait;
    logic       w_lu;
    logic       w_lu_phase;
    logic       w_sel_mem;
    logic       w_sel_mc;
    logic       w_sel_rd;
    logic       w_sel_lu;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_mem_wait = MemReqM & ~MemReadyM;

    assign w_lu = (ResultSrcE == RESULT_LOAD) & (RdE != '0)
                & ((RdE == Rs1D) | (RdE == Rs2D));

    // a suspended load-use stall resumes once mem/mc hazards clear
    assign w_lu_phase = (r_state == ST_LU_STALL) | r_lu_ret;

    // one-hot hazard selection in priority order
    assign w_sel_mem = w_mem_wait;
    assign w_sel_mc  = McBusyE & ~w_mem_wait;
    assign w_sel_rd  = PCSrcE & ~McBusyE & ~w_mem_wait;
    assign w_sel_lu  = (w_lu_phase | w_lu) & ~PCSrcE
                     & ~McBusyE & ~w_mem_wait;

    // stall/flush decode; all quiet while reset is held
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        FlushW = 1'b0;
        if (reset_n) begin
            unique case (1'b1)
                w_sel_mem: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                end
                w_sel_mc: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    FlushM = 1'b1;
                end
                w_sel_rd: begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end
                w_sel_lu: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
                default: ;
            endcase
        end
    end

    hazard_forward #(.REG_AW(REG_AW)) u_fwd_a (
        .i_rs          (Rs1E),
        .i_rd_m        (RdM),
        .i_rd_w        (RdW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_fwd         (w_fwd_a)
    );

    hazard_forward #(.REG_AW(REG_AW)) u_fwd_b (
        .i_rs          (Rs2E),
        .i_rd_m        (RdM),
        .i_rd_w        (RdW),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_fwd         (w_fwd_b)
    );

    assign ForwardAE  = reset_n ? w_fwd_a : FWD_REG;
    assign ForwardBE  = reset_n ? w_fwd_b : FWD_REG;
    assign MemTimeout = r_timeout;

    // hazard FSM, load-use countdown and memory watchdog
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_lu_cnt  <= '0;
            r_to_cnt  <= '0;
            r_lu_ret  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_mem_wait) begin
                if (r_to_cnt != TO_LIMIT) begin
                    r_to_cnt <= r_to_cnt + CNT_ONE;
                end
                if (r_to_cnt >= TO_LAST) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end

            unique case (1'b1)
                w_sel_mem: begin
                    r_state  <= ST_MEM_WAIT;
                    r_lu_ret <= w_lu_phase;
                end
                w_sel_mc: begin
                    r_state  <= ST_MC_EXEC;
                    r_lu_ret <= w_lu_phase;
                end
                w_sel_rd: begin
                    r_state  <= ST_IDLE;
                    r_lu_cnt <= '0;
                    r_lu_ret <= 1'b0;
                end
                w_sel_lu: begin
                    r_lu_ret <= 1'b0;
                    if (w_lu_phase) begin
                        if (r_lu_cnt <= CNT_ONE) begin
                            r_state  <= ST_IDLE;
                            r_lu_cnt <= '0;
                        end else begin
                            r_state  <= ST_LU_STALL;
                            r_lu_cnt <= r_lu_cnt - CNT_ONE;
                        end
                    end else if (LOAD_LAT > 1) begin
                        r_state  <= ST_LU_STALL;
                        r_lu_cnt <= LU_RELOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_lu_ret <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench: two controllers (LOAD_LAT=1/255 and LOAD_LAT=3/3)
// share stimulus; expected outputs are queued and checked at negedge.
module tb_hazard_ctrl_mc;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] fl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       to;
    } obs_t;

    localparam logic [7:0] P_NO = 8'b0000_0000;
    localparam logic [7:0] P_LU = 8'b1100_0100;
    localparam logic [7:0] P_MW = 8'b1111_0001;
    localparam logic [7:0] P_MC = 8'b1110_0010;
    localparam logic [7:0] P_RD = 8'b0000_1100;

    logic       clk;
    logic       reset_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, McBusyE, MemReqM, MemReadyM;

    logic [3:0] a_st, a_fl, b_st, b_fl;
    logic [1:0] a_fa, a_fb, b_fa, b_fb;
    logic       a_to, b_to;

    obs_t  q_a[$];
    obs_t  q_b[$];
    string q_nm[$];
    int    total = 0;
    int    bad   = 0;

    hazard_ctrl_mc #(
        .REG_AW(5), .LOAD_LAT(1), .MEM_TIMEOUT(255), .CNT_W(8)
    ) u_a (
        .clk(clk), .reset_n(reset_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .McBusyE(McBusyE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(a_st[3]), .StallD(a_st[2]),
        .StallE(a_st[1]), .StallM(a_st[0]),
        .FlushD(a_fl[3]), .FlushE(a_fl[2]),
        .FlushM(a_fl[1]), .FlushW(a_fl[0]),
        .ForwardAE(a_fa), .ForwardBE(a_fb), .MemTimeout(a_to)
    );

    hazard_ctrl_mc #(
        .REG_AW(5), .LOAD_LAT(3), .MEM_TIMEOUT(3), .CNT_W(8)
    ) u_b (
        .clk(clk), .reset_n(reset_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .McBusyE(McBusyE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(b_st[3]), .StallD(b_st[2]),
        .StallE(b_st[1]), .StallM(b_st[0]),
        .FlushD(b_fl[3]), .FlushE(b_fl[2]),
        .FlushM(b_fl[1]), .FlushW(b_fl[0]),
        .ForwardAE(b_fa), .ForwardBE(b_fb), .MemTimeout(b_to)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t mk(input logic [7:0] p,
                                input logic [1:0] fa,
                                input logic [1:0] fb,
                                input logic to);
        obs_t o;
        o.st = p[7:4];
        o.fl = p[3:0];
        o.fa = fa;
        o.fb = fb;
        o.to = to;
        return o;
    endfunction

    task automatic clr();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
        RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00;
        PCSrcE = 0; McBusyE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    // queue expectations for this cycle, then advance one clock
    task automatic step(input obs_t ea, input obs_t eb,
                        input string nm);
        q_a.push_back(ea);
        q_b.push_back(eb);
        q_nm.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic both(input logic [7:0] p, input string nm);
        step(mk(p, 2'b00, 2'b00, 1'b0),
             mk(p, 2'b00, 2'b00, 1'b0), nm);
    endtask

    // monitor: compare live outputs against the queued expectation
    always @(negedge clk) begin
        obs_t  ea, eb, ga, gb;
        string nm;
        if (q_nm.size() != 0) begin
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            nm = q_nm.pop_front();
            ga = {a_st, a_fl, a_fa, a_fb, a_to};
            gb = {b_st, b_fl, b_fa, b_fb, b_to};
            total++;
            if (ga !== ea) begin
                bad++;
                $display("FAIL %s dutA got=%b exp=%b", nm, ga, ea);
            end
            total++;
            if (gb !== eb) begin
                bad++;
                $display("FAIL %s dutB got=%b exp=%b", nm, gb, eb);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        clr();
        @(posedge clk);
        #1;

        // outputs forced quiet while reset is held
        ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
        MemReqM = 1; McBusyE = 1; PCSrcE = 1;
        RegWriteM = 1; RdM = 9; Rs1E = 9;
        both(P_NO, "in_reset");
        reset_n = 1'b1;
        clr();
        both(P_NO, "idle");

        // load-use on Rs1D: A stalls 1 cycle, B stalls 3
        ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
        both(P_LU, "lu_c1");
        clr();
        step(mk(P_NO, 0, 0, 0), mk(P_LU, 0, 0, 0), "lu_c2");
        step(mk(P_NO, 0, 0, 0), mk(P_LU, 0, 0, 0), "lu_c3");
        both(P_NO, "lu_done");

        // load into x0 never interlocks
        ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; Rs2D = 0;
        both(P_NO, "lu_x0");
        clr();

        // load-use on Rs2D aborted by redirect in cycle 2
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; Rs1D = 3;
        both(P_LU, "lu_rd_c1");
        clr();
        PCSrcE = 1;
        both(P_RD, "lu_rd_c2");
        PCSrcE = 0;
        both(P_NO, "lu_rd_c3");

        // mem wait freezes B's load-use countdown, which then resumes
        ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
        both(P_LU, "lu_mw_c1");
        clr();
        MemReqM = 1;
        both(P_MW, "lu_mw_c2");
        MemReadyM = 1;
        step(mk(P_NO, 0, 0, 0), mk(P_LU, 0, 0, 0), "lu_mw_c3");
        clr();
        step(mk(P_NO, 0, 0, 0), mk(P_LU, 0, 0, 0), "lu_mw_c4");
        both(P_NO, "lu_mw_c5");

        // 4 wait cycles: A no timeout, B (limit 3) sets after 3rd
        MemReqM = 1;
        for (int i = 0; i < 4; i++) begin
            step(mk(P_MW, 0, 0, 0), mk(P_MW, 0, 0, (i == 3)),
                 "memwait");
        end
        MemReadyM = 1;
        step(mk(P_NO, 0, 0, 0), mk(P_NO, 0, 0, 1), "mem_ready");
        clr();
        step(mk(P_NO, 0, 0, 0), mk(P_NO, 0, 0, 1), "to_sticky");
        reset_n = 1'b0;
        both(P_NO, "to_async_clr");
        reset_n = 1'b1;
        both(P_NO, "after_rst");

        // multi-cycle op masks redirect until busy drops
        McBusyE = 1; PCSrcE = 1;
        for (int i = 0; i < 6; i++) begin
            both(P_MC, "mc_busy");
        end
        McBusyE = 0;
        both(P_RD, "mc_then_rd");
        PCSrcE = 0;
        both(P_NO, "mc_done");

        // forwarding
        RegWriteM = 1; RegWriteW = 1; RdM = 9; RdW = 9;
        Rs1E = 9; Rs2E = 9;
        step(mk(P_NO, 2'b10, 2'b10, 0),
             mk(P_NO, 2'b10, 2'b10, 0), "fwd_m_wins");
        RegWriteM = 0;
        step(mk(P_NO, 2'b01, 2'b01, 0),
             mk(P_NO, 2'b01, 2'b01, 0), "fwd_w");
        Rs1E = 0;
        step(mk(P_NO, 2'b00, 2'b01, 0),
             mk(P_NO, 2'b00, 2'b01, 0), "fwd_rs0");
        RegWriteM = 1; RdM = 4; Rs2E = 4; Rs1E = 9;
        step(mk(P_NO, 2'b01, 2'b10, 0),
             mk(P_NO, 2'b01, 2'b10, 0), "fwd_split");
        RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
        both(P_NO, "fwd_x0");

        // forwarding stays live during a mem wait
        RegWriteM = 0; RegWriteW = 1; RdW = 3; Rs1E = 3;
        MemReqM = 1;
        step(mk(P_MW, 2'b01, 2'b00, 0),
             mk(P_MW, 2'b01, 2'b00, 0), "fwd_in_mw");
        clr();
        both(P_NO, "end_idle");

        for (int i = 0; i < 4 && q_nm.size() != 0; i++) begin
            @(posedge clk);
        end
        if (q_nm.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", q_nm.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
